frame_sequencer: RTL and testbench

Frame sequencer for the APU. It divides the CPU-rate tick into frame steps and emits the quarter-frame and half-frame strobes. The quarter-frame strobe clocks the envelope. The half-frame strobe clocks the length counter and the sweep unit. The block also raises the frame interrupt. One instance drives the iEnvelope_clk, iLength_clk and iSweep_clk inputs of every pulseChannel, and of the other channels, under control of register $4017.

---
 rtl/frame_sequencer.sv | 128 ++++++++++++
 tb/tb_frame_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: divides the CPU-rate tick into frame steps and emits the
// quarter-frame (envelope) and half-frame (length/sweep) strobes, plus the
// frame interrupt, under control of register $4017.
module frame_sequencer #(
  parameter int STEP_CYCLES = 7457,
  parameter int DIV_W       = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       reg4017_write,
  input  logic [7:0] reg4017,
  input  logic       irq_ack,
  output logic       quarter_clk,
  output logic       half_clk,
  output logic       frame_irq
);

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } step_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);

  logic             mode_q, mode_d;
  logic             irq_inhibit_q, irq_inhibit_d;
  logic [DIV_W-1:0] div_q, div_d;
  step_e            step_q, step_d;
  logic             quarter_q, quarter_d;
  logic             half_q, half_d;
  logic             irq_q, irq_d;
  logic             irq_set;
  step_e            step_last;

  // Bits 5:0 of $4017 carry nothing for this block.
  logic unused_reg_bits;
  assign unused_reg_bits = ^reg4017[5:0];

  // Register all state; reset also drops any strobe that was about to fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q        <= 1'b0;
      irq_inhibit_q <= 1'b0;
      div_q         <= '0;
      step_q        <= STEP0;
      quarter_q     <= 1'b0;
      half_q        <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      irq_inhibit_q <= irq_inhibit_d;
      div_q         <= div_d;
      step_q        <= step_d;
      quarter_q     <= quarter_d;
      half_q        <= half_d;
      irq_q         <= irq_d;
    end
  end

  // Next-state: a $4017 write overrides the divider completely, otherwise a
  // tick advances the divider and a wrap completes the current step.
  always_comb begin
    mode_d        = mode_q;
    irq_inhibit_d = irq_inhibit_q;
    div_d         = div_q;
    step_d        = step_q;
    quarter_d     = 1'b0;
    half_d        = 1'b0;
    irq_set       = 1'b0;
    irq_d         = irq_q;
    step_last     = mode_q ? STEP4 : STEP3;

    if (reg4017_write) begin
      mode_d        = reg4017[7];
      irq_inhibit_d = reg4017[6];
      div_d         = '0;
      step_d        = STEP0;
      if (reg4017[7]) begin
        quarter_d = 1'b1;
        half_d    = 1'b1;
      end
    end else if (tick) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        case (step_q)
          STEP0: quarter_d = 1'b1;
          STEP1: begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
          end
          STEP2: quarter_d = 1'b1;
          STEP3: begin
            if (!mode_q) begin
              quarter_d = 1'b1;
              half_d    = 1'b1;
              irq_set   = !irq_inhibit_q;
            end
          end
          STEP4: begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
          end
          default: ;
        endcase
        step_d = (step_q == step_last) ? STEP0 : step_e'(step_q + 3'd1);
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (reg4017_write && reg4017[6]) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  assign quarter_clk = quarter_q;
  assign half_clk    = half_q;
  assign frame_irq   = irq_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a short step (STEP_CYCLES=4).
// A cycle-by-cycle vector table covers steady 4-step running, IRQ handling,
// 5-step mode and the write/step collision; hand-written sequences cover
// sparse ticks and a reset in the middle of a frame.
module tb_frame_sequencer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       reg4017_write;
  logic [7:0] reg4017;
  logic       irq_ack;
  logic       quarter_clk;
  logic       half_clk;
  logic       frame_irq;

  int compCount = 0;
  int failCount = 0;

  typedef struct {
    logic       rst;
    logic       tck;
    logic       wr;
    logic [7:0] data;
    logic       ack;
    logic       expQ;
    logic       expH;
    logic       expIrq;
  } vec_t;

  vec_t vecs[$];

  frame_sequencer #(.STEP_CYCLES(4), .DIV_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .reg4017_write(reg4017_write),
    .reg4017(reg4017),
    .irq_ack(irq_ack),
    .quarter_clk(quarter_clk),
    .half_clk(half_clk),
    .frame_irq(frame_irq)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append one cycle of stimulus with its expected registered outputs.
  task automatic push(input logic r, input logic t, input logic w, input logic [7:0] d,
                      input logic a, input logic q, input logic h, input logic i);
    vec_t v;
    v.rst = r; v.tck = t; v.wr = w; v.data = d; v.ack = a;
    v.expQ = q; v.expH = h; v.expIrq = i;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic r, input logic t, input logic w,
                               input logic [7:0] d, input logic a);
    reset = r;
    tick = t;
    reg4017_write = w;
    reg4017 = d;
    irq_ack = a;
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against expectations.
  task automatic checkOutput(input string name, input logic q, input logic h, input logic i);
    compCount++;
    if (quarter_clk !== q) begin
      failCount++;
      $display("[TB] FAIL %s quarter_clk: got %b want %b", name, quarter_clk, q);
    end
    compCount++;
    if (half_clk !== h) begin
      failCount++;
      $display("[TB] FAIL %s half_clk: got %b want %b", name, half_clk, h);
    end
    compCount++;
    if (frame_irq !== i) begin
      failCount++;
      $display("[TB] FAIL %s frame_irq: got %b want %b", name, frame_irq, i);
    end
  endtask

  // Sparse tick, one tick every third cycle: strobes at cycles 12 and 24.
  task automatic runSparse();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("sparseReset", 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 26; c++) begin
      applyStimulus(1'b0, (c % 3) == 0, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("sparse%0d", c), (c == 12) || (c == 24), c == 24, 1'b0);
    end
  endtask

  // Run to div=2, step=3, then reset: nothing fires, counting restarts.
  task automatic runResetMid();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("midReset0", 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("midRun%0d", c), (c % 4) == 0, (c % 8) == 0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("midResetHit", 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("midAfter%0d", c), (c % 4) == 0, c == 8, 1'b0);
    end
  endtask

  // Build the vector table, play it back, then the hand-written sequences.
  initial begin
    reset = 1'b1;
    tick = 1'b0;
    reg4017_write = 1'b0;
    reg4017 = 8'h00;
    irq_ack = 1'b0;

    push(1, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int c = 1; c <= 32; c++)
      push(0, 1, 0, 8'h00, 0, (c % 4) == 0, (c % 8) == 0, c >= 16);
    for (int c = 33; c <= 48; c++)
      push(0, 1, 0, 8'h00, (c == 33) || (c == 48), (c % 4) == 0, (c % 8) == 0, c == 48);
    push(0, 1, 1, 8'h40, 0, 0, 0, 0);
    for (int r = 1; r <= 48; r++)
      push(0, 1, 0, 8'h00, 0, (r % 4) == 0, (r % 8) == 0, 0);
    push(0, 1, 1, 8'h80, 0, 1, 1, 0);
    for (int r = 1; r <= 67; r++)
      push(0, 1, 0, 8'h00, 0, (r % 20) inside {0, 4, 8, 12}, (r % 20) inside {0, 8}, 0);
    push(0, 1, 1, 8'h00, 0, 0, 0, 0);
    for (int r = 1; r <= 8; r++)
      push(0, 1, 0, 8'h00, 0, (r % 4) == 0, r == 8, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].tck, vecs[i].wr, vecs[i].data, vecs[i].ack);
      checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expH, vecs[i].expIrq);
    end

    runSparse();
    runResetMid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
